// File: rtl/car_parking_pkg.sv
// Shared types and constants for the parking gate controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package car_parking_pkg;

  typedef enum logic [2:0] {
    IDLE             = 3'd0,
    PASSWORD_WAITING = 3'd1,
    WRONG_PASSWORD   = 3'd2,
    CORRECT_PASSWORD = 3'd3,
    WAIT             = 3'd4,
    LOCKOUT          = 3'd5
  } state_t;

  // Active-low 7-segment status codes
  localparam logic [6:0] HEX_BLANK    = 7'b111_1111;
  localparam logic [6:0] HEX_FULL     = 7'b000_1110;
  localparam logic [6:0] HEX_PW_WAIT  = 7'b011_0000;
  localparam logic [6:0] HEX_PW_WRONG = 7'b011_1000;
  localparam logic [6:0] HEX_PW_OK    = 7'b011_0001;
  localparam logic [6:0] HEX_WAIT     = 7'b010_0100;
  localparam logic [6:0] HEX_LOCKOUT  = 7'b100_0111;

  // Bits needed to hold a count of 0..slots inclusive
  function automatic int occ_width(input int slots);
    return $clog2(slots + 1);
  endfunction

endpackage

// File: rtl/parking_occupancy_counter.sv
// Saturating up/down count of cars in the lot, with a registered full flag.
// Latency: occupancy and full update one edge after inc/dec.
// Backpressure: none; inc at capacity and dec at zero are absorbed.
module parking_occupancy_counter
  import car_parking_pkg::*;
#(
  parameter int NUM_SLOTS = 8,
  parameter int OCC_W     = occ_width(NUM_SLOTS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [OCC_W-1:0] occupancy,
  output logic             full
);

  localparam logic [OCC_W-1:0] MAX_OCC = OCC_W'(NUM_SLOTS);

  logic [OCC_W-1:0] occ_next;

  // Simultaneous inc and dec cancel; both ends saturate
  always_comb begin
    occ_next = occupancy;
    if (inc && !dec && occupancy != MAX_OCC)
      occ_next = occupancy + OCC_W'(1);
    else if (dec && !inc && occupancy != '0)
      occ_next = occupancy - OCC_W'(1);
  end

  // Register count and derive full from the same next value so they agree
  always_ff @(posedge clk) begin
    if (reset) begin
      occupancy <= '0;
      full      <= 1'b0;
    end else begin
      occupancy <= occ_next;
      full      <= (occ_next == MAX_OCC);
    end
  end

endmodule

// File: rtl/car_parking_controller.sv
// Gate controller: password FSM with timeout, retry lockout and lot-full refusal.
// Latency: outputs registered from next_state, valid alongside the new state.
// Backpressure: none; strobes outside password-accepting states are dropped.
module car_parking_controller
  import car_parking_pkg::*;
#(
  parameter int              NUM_SLOTS      = 8,
  parameter int              PW_W           = 4,
  parameter logic [PW_W-1:0] PASSWORD       = 4'b0111,
  parameter int              PW_TIMEOUT     = 16,
  parameter int              MAX_TRIES      = 3,
  parameter int              LOCKOUT_CYCLES = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               entrance_sensor,
  input  logic                               exit_sensor,
  input  logic                               leave_sensor,
  input  logic [PW_W-1:0]                    password_in,
  input  logic                               password_valid,
  output logic                               green_light,
  output logic                               red_light,
  output logic [6:0]                         hex1,
  output logic [occ_width(NUM_SLOTS)-1:0]    occupancy,
  output logic                               full,
  output logic                               locked
);

  localparam int TMR_W = $clog2(PW_TIMEOUT);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam int LCK_W = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PW_TIMEOUT - 1);
  localparam logic [TRY_W-1:0] TRY_MAX  = TRY_W'(MAX_TRIES);
  localparam logic [LCK_W-1:0] LCK_LAST = LCK_W'(LOCKOUT_CYCLES - 1);

  state_t           state, next_state;
  logic [TMR_W-1:0] timer, timer_next;
  logic [TRY_W-1:0] tries, tries_next, try_inc;
  logic [LCK_W-1:0] lock_cnt, lock_next;
  logic             match, refuse, pass;

  assign match   = password_valid && (password_in == PASSWORD);
  assign try_inc = tries + TRY_W'(1);

  // Next-state, retry, timer and lockout-counter decisions
  always_comb begin
    next_state = state;
    tries_next = tries;
    timer_next = '0;
    lock_next  = '0;
    refuse     = 1'b0;
    pass       = 1'b0;
    case (state)
      IDLE: begin
        if (entrance_sensor) begin
          if (full) refuse = 1'b1;
          else      next_state = PASSWORD_WAITING;
        end
      end
      PASSWORD_WAITING, WRONG_PASSWORD: begin
        // A strobe wins over the timeout; any mismatch restarts the timer
        if (match) begin
          next_state = CORRECT_PASSWORD;
          tries_next = '0;
        end else if (password_valid) begin
          tries_next = try_inc;
          next_state = (try_inc == TRY_MAX) ? LOCKOUT : WRONG_PASSWORD;
        end else if (timer == TMR_LAST) begin
          next_state = IDLE;
          tries_next = '0;
        end else begin
          timer_next = timer + TMR_W'(1);
        end
      end
      CORRECT_PASSWORD: begin
        if (exit_sensor) begin
          pass       = 1'b1;
          next_state = entrance_sensor ? WAIT : IDLE;
        end
      end
      WAIT: begin
        // Tailgater must re-authenticate; misses here do not count as tries
        if (match) next_state = full ? IDLE : CORRECT_PASSWORD;
      end
      LOCKOUT: begin
        if (lock_cnt == LCK_LAST) begin
          next_state = IDLE;
          tries_next = '0;
        end else begin
          lock_next = lock_cnt + LCK_W'(1);
        end
      end
      default: begin
        next_state = IDLE;
        tries_next = '0;
      end
    endcase
  end

  // State, counters and registered outputs decoded from next_state
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      tries       <= '0;
      lock_cnt    <= '0;
      green_light <= 1'b0;
      red_light   <= 1'b0;
      hex1        <= HEX_BLANK;
      locked      <= 1'b0;
    end else begin
      state       <= next_state;
      timer       <= timer_next;
      tries       <= tries_next;
      lock_cnt    <= lock_next;
      green_light <= (next_state == CORRECT_PASSWORD);
      locked      <= (next_state == LOCKOUT);
      case (next_state)
        PASSWORD_WAITING: begin red_light <= 1'b1; hex1 <= HEX_PW_WAIT;  end
        WRONG_PASSWORD:   begin red_light <= 1'b1; hex1 <= HEX_PW_WRONG; end
        CORRECT_PASSWORD: begin red_light <= 1'b0; hex1 <= HEX_PW_OK;    end
        WAIT:             begin red_light <= 1'b1; hex1 <= HEX_WAIT;     end
        LOCKOUT:          begin red_light <= 1'b1; hex1 <= HEX_LOCKOUT;  end
        default: begin
          red_light <= refuse;
          hex1      <= refuse ? HEX_FULL : HEX_BLANK;
        end
      endcase
    end
  end

  parking_occupancy_counter #(
    .NUM_SLOTS (NUM_SLOTS)
  ) u_occ (
    .clk       (clk),
    .reset     (reset),
    .inc       (pass),
    .dec       (leave_sensor),
    .occupancy (occupancy),
    .full      (full)
  );

endmodule

// File: tb/tb_car_parking_controller.sv
// Randomised and directed bench for car_parking_controller against a behavioural model.
// Latency: each stimulus cycle is checked 1 time unit after its rising edge.
// Backpressure: n/a.
module tb_car_parking_controller;

  localparam int         N   = 8;
  localparam int         TO  = 16;
  localparam int         MT  = 3;
  localparam int         LC  = 32;
  localparam logic [3:0] PW  = 4'b0111;
  localparam logic [3:0] BAD = 4'b0001;

  logic       clk;
  logic       reset;
  logic       entrance_sensor, exit_sensor, leave_sensor, password_valid;
  logic [3:0] password_in;
  logic       green_light, red_light, full, locked;
  logic [6:0] hex1;
  logic [3:0] occupancy;

  car_parking_controller dut (
    .clk             (clk),
    .reset           (reset),
    .entrance_sensor (entrance_sensor),
    .exit_sensor     (exit_sensor),
    .leave_sensor    (leave_sensor),
    .password_in     (password_in),
    .password_valid  (password_valid),
    .green_light     (green_light),
    .red_light       (red_light),
    .hex1            (hex1),
    .occupancy       (occupancy),
    .full            (full),
    .locked          (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of the gate
  typedef enum {M_IDLE, M_PWW, M_WRONG, M_OK, M_WAIT, M_LOCK} mst_t;
  mst_t       m_state;
  int         m_tries, m_cnt, m_occ;
  logic       e_green, e_red, e_locked;
  logic [6:0] e_hex;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check_eq("green",     green_light, e_green);
    check_eq("red",       red_light,   e_red);
    check_eq("hex1",      hex1,        e_hex);
    check_eq("locked",    locked,      e_locked);
    check_eq("occupancy", occupancy,   m_occ);
    check_eq("full",      full,        m_occ == N);
  endtask

  task automatic model_reset();
    m_state = M_IDLE; m_tries = 0; m_cnt = 0; m_occ = 0;
    e_green = 0; e_red = 0; e_locked = 0; e_hex = 7'b111_1111;
  endtask

  task automatic model_step(input bit ent, ex, lv, pv, input logic [3:0] pw);
    bit   match, miss, pass, refuse;
    mst_t nx;
    int   t;
    match = pv && (pw == PW);
    miss  = pv && !match;
    pass = 0; refuse = 0;
    nx = m_state;
    case (m_state)
      M_IDLE: if (ent) begin if (m_occ == N) refuse = 1; else nx = M_PWW; end
      M_PWW, M_WRONG: begin
        if (match) begin nx = M_OK; m_tries = 0; end
        else if (miss) begin m_tries++; nx = (m_tries == MT) ? M_LOCK : M_WRONG; end
        else if (m_cnt == TO - 1) begin nx = M_IDLE; m_tries = 0; end
      end
      M_OK:   if (ex) begin pass = 1; nx = ent ? M_WAIT : M_IDLE; end
      M_WAIT: if (match) nx = (m_occ == N) ? M_IDLE : M_OK;
      M_LOCK: if (m_cnt == LC - 1) begin nx = M_IDLE; m_tries = 0; end
      default: nx = M_IDLE;
    endcase
    // cycles spent in the current state, restarted by entry or a fresh miss
    if (nx != m_state || (miss && m_state inside {M_PWW, M_WRONG})) m_cnt = 0;
    else m_cnt++;
    t = m_occ + int'(pass) - int'(lv);
    m_occ = (t < 0) ? 0 : (t > N) ? N : t;
    m_state  = nx;
    e_green  = (nx == M_OK);
    e_locked = (nx == M_LOCK);
    e_red    = (nx inside {M_PWW, M_WRONG, M_WAIT, M_LOCK}) || refuse;
    case (nx)
      M_PWW:   e_hex = 7'b011_0000;
      M_WRONG: e_hex = 7'b011_1000;
      M_OK:    e_hex = 7'b011_0001;
      M_WAIT:  e_hex = 7'b010_0100;
      M_LOCK:  e_hex = 7'b100_0111;
      default: e_hex = refuse ? 7'b000_1110 : 7'b111_1111;
    endcase
  endtask

  task automatic cyc(input bit ent, ex, lv, pv, input logic [3:0] pw);
    @(negedge clk);
    entrance_sensor = ent; exit_sensor = ex; leave_sensor = lv;
    password_valid  = pv;  password_in = pw;
    model_step(ent, ex, lv, pv, pw);
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(posedge clk); #1;
    check_all();
    reset = 1'b0;
  endtask

  // One car through the gate from IDLE
  task automatic car_in();
    cyc(1, 0, 0, 0, 4'h0);
    cyc(0, 0, 0, 1, PW);
    cyc(0, 1, 0, 0, 4'h0);
  endtask

  initial begin
    reset = 1'b1; entrance_sensor = 0; exit_sensor = 0; leave_sensor = 0;
    password_valid = 0; password_in = '0;

    // Basic entry: strobe on third cycle, then pass
    do_reset();
    cyc(1, 0, 0, 0, 4'h0);
    cyc(1, 0, 0, 0, 4'h0);
    cyc(1, 0, 0, 1, PW);
    check_eq("ok_green", green_light, 1'b1);
    cyc(0, 1, 0, 0, 4'h0);
    check_eq("pass_occ", occupancy, 4'd1);

    // Three misses lock out for exactly LC cycles; correct strobe ignored
    do_reset();
    cyc(1, 0, 0, 0, 4'h0);
    cyc(0, 0, 0, 1, BAD);
    cyc(0, 0, 0, 1, BAD);
    cyc(0, 0, 0, 1, BAD);
    check_eq("lock_on", locked, 1'b1);
    for (int i = 0; i < LC - 1; i++) cyc(1, 0, 0, (i == 3), PW);
    check_eq("lock_hold", locked, 1'b1);
    cyc(0, 0, 0, 0, 4'h0);
    check_eq("lock_off", locked, 1'b0);

    // Timeout after TO cycles; strobe in last cycle wins; tries cleared by timeout
    do_reset();
    cyc(1, 0, 0, 0, 4'h0);
    repeat (TO - 1) cyc(0, 0, 0, 0, 4'h0);
    check_eq("to_hold", hex1, 7'b011_0000);
    cyc(0, 0, 0, 0, 4'h0);
    check_eq("to_idle", hex1, 7'b111_1111);
    cyc(1, 0, 0, 0, 4'h0);
    repeat (TO - 1) cyc(0, 0, 0, 0, 4'h0);
    cyc(0, 0, 0, 1, PW);
    check_eq("to_edge_ok", green_light, 1'b1);
    cyc(0, 1, 0, 0, 4'h0);
    cyc(1, 0, 0, 0, 4'h0);
    cyc(0, 0, 0, 1, BAD);
    repeat (TO) cyc(0, 0, 0, 0, 4'h0);
    cyc(1, 0, 0, 0, 4'h0);
    repeat (TO - 1) cyc(0, 0, 0, 0, 4'h0);
    cyc(0, 0, 0, 1, BAD);
    cyc(0, 0, 0, 1, BAD);
    check_eq("tries_cleared", locked, 1'b0);

    // Full lot refuses entry; a leave reopens it; WAIT with full lot -> IDLE
    do_reset();
    repeat (N) car_in();
    cyc(1, 0, 0, 0, 4'h0);
    cyc(1, 0, 0, 0, 4'h0);
    check_eq("refuse_hex", hex1, 7'b000_1110);
    check_eq("refuse_red", red_light, 1'b1);
    cyc(1, 0, 1, 0, 4'h0);
    check_eq("leave_full", full, 1'b0);
    cyc(1, 0, 0, 0, 4'h0);
    cyc(0, 0, 0, 1, PW);
    cyc(1, 1, 0, 0, 4'h0);
    check_eq("wait_full", full, 1'b1);
    cyc(0, 0, 0, 1, PW);
    check_eq("wait_full_idle", hex1, 7'b111_1111);

    // Tailgate: WAIT ignores miss count, match returns to CORRECT_PASSWORD
    do_reset();
    cyc(1, 0, 0, 0, 4'h0);
    cyc(0, 0, 0, 1, PW);
    cyc(1, 1, 0, 0, 4'h0);
    check_eq("tailgate_hex", hex1, 7'b010_0100);
    repeat (MT) cyc(0, 0, 0, 1, BAD);
    cyc(0, 0, 0, 1, PW);
    cyc(0, 1, 0, 0, 4'h0);
    cyc(1, 0, 0, 0, 4'h0);
    cyc(0, 0, 0, 1, BAD);
    cyc(0, 0, 0, 1, BAD);
    check_eq("wait_no_tries", locked, 1'b0);

    // Occupancy edges and reset from WAIT
    do_reset();
    cyc(0, 0, 1, 0, 4'h0);
    car_in();
    cyc(1, 0, 0, 0, 4'h0);
    cyc(0, 0, 0, 1, PW);
    cyc(0, 1, 1, 0, 4'h0);
    check_eq("inc_dec", occupancy, 4'd1);
    cyc(1, 0, 0, 0, 4'h0);
    cyc(0, 0, 0, 1, PW);
    cyc(1, 1, 0, 0, 4'h0);
    do_reset();

    // Randomised traffic
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      else cyc($urandom_range(0, 1), $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
               $urandom_range(0, 3) == 0,
               ($urandom_range(0, 1) != 0) ? PW : 4'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
